// File: rtl/cmd_issuer.sv
// Host-side command initiator: validates framed requests from the host link,
// drives one command onto the command bus, and returns a framed response.
module cmd_issuer #(
  parameter int unsigned TIMEOUT = 1000000,
  parameter logic [7:0]  SYNC_RX = 8'hA5,
  parameter logic [7:0]  SYNC_TX = 8'h5A
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_cmd_come,
  output logic [15:0] o_cmd,
  output logic [31:0] o_cmd_param,
  input  logic        i_finish,
  input  logic [15:0] i_finish_code,
  output logic        o_busy,
  output logic [7:0]  o_err_cnt
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_CHK_ERR = 8'h01;
  localparam logic [7:0] ST_TIMEOUT = 8'h02;

  typedef enum logic [2:0] {HUNT, RECV, CHECK, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  logic [7:0]       rx_buf [7];
  logic [2:0]       rx_idx;
  logic [7:0]       rx_xor;
  logic [15:0]      rsp_code;
  logic [7:0]       rsp_status;
  logic [2:0]       tx_idx;
  logic [CNT_W-1:0] wait_cnt;
  logic             fin_s1, fin_s2, fin_d;
  logic             fin_rise_c;
  logic [7:0]       rsp_chk_c;
  logic [7:0]       next_tx_c;

  assign fin_rise_c = fin_s2 & ~fin_d;
  assign rsp_chk_c  = rx_buf[0] ^ rx_buf[1] ^ rsp_code[15:8] ^ rsp_code[7:0] ^ rsp_status;

  // Response byte that follows the one currently at index tx_idx.
  always_comb begin
    next_tx_c = rsp_chk_c;
    case (tx_idx)
      3'd0:    next_tx_c = rx_buf[0];
      3'd1:    next_tx_c = rx_buf[1];
      3'd2:    next_tx_c = rsp_code[15:8];
      3'd3:    next_tx_c = rsp_code[7:0];
      3'd4:    next_tx_c = rsp_status;
      default: next_tx_c = rsp_chk_c;
    endcase
  end

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= HUNT;
      o_rx_ready  <= 1'b0;
      o_tx_data   <= 8'h00;
      o_tx_valid  <= 1'b0;
      o_cmd_come  <= 1'b0;
      o_cmd       <= 16'h0000;
      o_cmd_param <= 32'h0000_0000;
      o_busy      <= 1'b0;
      o_err_cnt   <= 8'h00;
      rx_idx      <= 3'd0;
      rx_xor      <= 8'h00;
      rsp_code    <= 16'h0000;
      rsp_status  <= ST_OK;
      tx_idx      <= 3'd0;
      wait_cnt    <= '0;
      fin_s1      <= 1'b0;
      fin_s2      <= 1'b0;
      fin_d       <= 1'b0;
      for (int i = 0; i < 7; i++) rx_buf[i] <= 8'h00;
    end else begin
      // Two sync flops plus one edge flop for the foreign-domain finish level.
      fin_s1 <= i_finish;
      fin_s2 <= fin_s1;
      fin_d  <= fin_s2;

      case (state)
        HUNT: begin
          o_rx_ready <= 1'b1;
          if (i_rx_valid && o_rx_ready && (i_rx_data == SYNC_RX)) begin
            state  <= RECV;
            rx_idx <= 3'd0;
            rx_xor <= 8'h00;
            o_busy <= 1'b1;
          end
        end

        RECV: begin
          if (i_rx_valid && o_rx_ready) begin
            rx_buf[rx_idx] <= i_rx_data;
            if (rx_idx == 3'd6) begin
              o_rx_ready <= 1'b0;
              state      <= CHECK;
            end else begin
              rx_xor <= rx_xor ^ i_rx_data;
              rx_idx <= rx_idx + 3'd1;
            end
          end
        end

        CHECK: begin
          if (rx_xor == rx_buf[6]) begin
            o_cmd       <= {rx_buf[0], rx_buf[1]};
            o_cmd_param <= {rx_buf[2], rx_buf[3], rx_buf[4], rx_buf[5]};
            state       <= ISSUE;
          end else begin
            rsp_code   <= 16'h0000;
            rsp_status <= ST_CHK_ERR;
            o_err_cnt  <= sat_inc(o_err_cnt);
            o_tx_valid <= 1'b1;
            o_tx_data  <= SYNC_TX;
            tx_idx     <= 3'd0;
            state      <= RESP;
          end
        end

        ISSUE: begin
          o_cmd_come <= 1'b1;
          wait_cnt   <= '0;
          state      <= WAIT;
        end

        WAIT: begin
          // Completion is checked first so it wins over a coincident timeout.
          if (fin_rise_c) begin
            rsp_code   <= i_finish_code;
            rsp_status <= ST_OK;
            o_cmd_come <= 1'b0;
            o_tx_valid <= 1'b1;
            o_tx_data  <= SYNC_TX;
            tx_idx     <= 3'd0;
            state      <= RESP;
          end else if (wait_cnt == CNT_LAST) begin
            rsp_code   <= 16'hFFFF;
            rsp_status <= ST_TIMEOUT;
            o_err_cnt  <= sat_inc(o_err_cnt);
            o_cmd_come <= 1'b0;
            o_tx_valid <= 1'b1;
            o_tx_data  <= SYNC_TX;
            tx_idx     <= 3'd0;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        RESP: begin
          if (i_tx_ready) begin
            if (tx_idx == 3'd6) begin
              o_tx_valid <= 1'b0;
              o_busy     <= 1'b0;
              o_rx_ready <= 1'b1;
              state      <= HUNT;
            end else begin
              o_tx_data <= next_tx_c;
              tx_idx    <= tx_idx + 3'd1;
            end
          end
        end

        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: doc/cmd_issuer.md
Name: cmd_issuer

Overview:
- Host-side initiator for the command-processor handshake (cmd_come / cmd / param -> finish / finish_code).
- Receives framed command packets as a byte stream from the host link (USB FIFO side) and validates them.
- Drives one command at a time onto the command bus, waits for completion, then returns a framed response byte stream to the host.
- Tolerates a command processor on another clock domain: i_finish is synchronized internally, and o_cmd_come is a level held until completion.

Parameters:
- TIMEOUT, 1000000, number of cycles WAIT state tolerates without seeing finish; minimum 8.
- SYNC_RX, 8'hA5, request frame sync byte.
- SYNC_TX, 8'h5A, response frame sync byte.

Ports:
- i_clk  in  1  clock; single clock domain for this block.
- i_rst  in  1  reset; synchronous, active-high.
- i_rx_data  in  8  request byte from host link.
- i_rx_valid  in  1  i_rx_data valid.
- o_rx_ready  out  1  block accepts a byte when valid&ready.
- o_tx_data  out  8  response byte to host link.
- o_tx_valid  out  1  o_tx_data valid.
- i_tx_ready  in  1  host link accepts a byte when valid&ready.
- o_cmd_come  out  1  command request level to the command processor.
- o_cmd  out  16  command code.
- o_cmd_param  out  32  command parameter.
- i_finish  in  1  completion level from the command processor; asynchronous.
- i_finish_code  in  16  completion code; stable while i_finish is high.
- o_busy  out  1  high in every state except HUNT.
- o_err_cnt  out  8  count of checksum errors plus timeouts; saturates at 255.

Behaviour:
- Reset values: o_rx_ready=0, o_tx_valid=0, o_tx_data=0, o_cmd_come=0, o_cmd=0, o_cmd_param=0, o_busy=0, o_err_cnt=0, finish synchronizer=0, state=HUNT.
- Reset mid-frame or mid-command aborts everything. o_cmd_come drops on the next edge; no response is sent.
- Request frame is 8 bytes: SYNC_RX, cmd[15:8], cmd[7:0], p[31:24], p[23:16], p[15:8], p[7:0], chk. chk is the XOR of bytes 1..6.
- Response frame is 7 bytes: SYNC_TX, cmd[15:8], cmd[7:0], code[15:8], code[7:0], status, chk. chk is the XOR of bytes 1..5.
- Status values: 00 = ok, 01 = checksum error, 02 = timeout.
- o_rx_ready=1 only in HUNT and RECV.
- HUNT:
  - Consumes bytes.
  - A byte equal to SYNC_RX -> RECV with the byte index cleared; any other byte is discarded.
- RECV:
  - Stores 7 bytes with a running XOR over the first 6.
  - On acceptance of the 7th byte (chk) -> CHECK.
  - A SYNC_RX value inside the payload is treated as data.
- CHECK (1 cycle):
  - Checksum match: load o_cmd/o_cmd_param, then -> ISSUE.
  - Mismatch: status=01, code=0000, o_err_cnt++, then -> RESP. o_cmd and o_cmd_param are not touched.
- ISSUE (1 cycle):
  - o_cmd_come rises at the end of this cycle, so o_cmd and o_cmd_param are stable at least 1 cycle before o_cmd_come rises.
  - Then -> WAIT.
- WAIT:
  - i_finish passes through 2 sync flops plus 1 edge flop. A rising edge of the synchronized level marks completion.
  - A level that was already high on entry does not count; a rising edge is required.
  - On completion: capture i_finish_code, set status=00, drop o_cmd_come, -> RESP.
  - A cycle counter counts from WAIT entry. If it reaches TIMEOUT-1 with no edge: code=FFFF, status=02, o_err_cnt++, drop o_cmd_come, -> RESP.
  - If completion and timeout land in the same cycle, completion wins.
- o_cmd and o_cmd_param are held unchanged from CHECK until the next successful CHECK.
- RESP:
  - Sends 7 bytes with valid/ready.
  - o_tx_data is stable while o_tx_valid&!i_tx_ready.
  - o_tx_valid is continuous across bytes, with no idle cycle required.
  - After the last byte is accepted: o_tx_valid=0, -> HUNT.
- Minimum o_cmd_come low time between commands is ≥ 9 cycles (RESP plus the next frame). This satisfies the downstream 2-flop edge detector.
- o_err_cnt holds at 255 once it saturates.

Test Plan:
- Good frame A5 00 01 00 00 00 00 01. The model raises finish 6 cycles after o_cmd_come with code 0000 -> o_cmd=0001, o_cmd_param=0. o_cmd_come rises 1 cycle after o_cmd loads and falls within 4 cycles of the finish edge. Response is 5A 00 01 00 00 00 01.
- Frame A5 00 05 00 64 00 0A 6B (chk=05^64^0A) with tx_ready toggling 1/0 -> o_cmd=0005, o_cmd_param=0064000A. Response is 5A 00 05 00 00 00 05, with o_tx_data held on every stall.
- Bad checksum A5 00 02 00 00 00 00 FF -> o_cmd_come never rises. Response is 5A 00 02 00 00 01 03, and o_err_cnt=1.
- No finish, TIMEOUT=8 -> o_cmd_come drops exactly 8 cycles after WAIT entry. Response is 5A 00 01 FF FF 02 03, and o_err_cnt increments.
- Garbage 11 22 then a good frame, with finish held high from a previous command at WAIT entry (model drops it then re-raises) -> garbage is discarded. Completion is taken only on the re-raise, not the initial high level.
- Assert i_rst for 1 cycle during WAIT -> all outputs reach their reset values on the next edge. A following good frame completes normally.
